// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB first, even parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] TxData,
  input  logic              valid_tx,
  output logic              ready_tx,
  output logic              TxD,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [DATA_W-1:0]   shift_r, shift_s;
  logic                parity_r, parity_s;
  logic                bit_end_s, txd_s, done_s;

  // Next-state, counters and datapath; outputs are derived from the next state so they register cleanly
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    shift_s   = shift_r;
    parity_s  = parity_r;
    bit_end_s = (cnt_r == CNT_LAST);
    case (state_r)
      ST_IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        idx_s = {IDX_W{1'b0}};
        if (valid_tx && ready_tx) begin
          shift_s  = TxData;
          parity_s = even_parity(TxData);
          state_s  = ST_START;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          cnt_s   = {CNT_W{1'b0}};
          idx_s   = {IDX_W{1'b0}};
          state_s = ST_DATA;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1'b1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_s   = {CNT_W{1'b0}};
          shift_s = {1'b0, shift_r[DATA_W-1:1]};
          if (idx_r == DATA_LAST) begin
            idx_s   = {IDX_W{1'b0}};
            state_s = ST_PARITY;
          end else begin
            idx_s   = idx_r + IDX_W'(1'b1);
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          cnt_s   = {CNT_W{1'b0}};
          idx_s   = {IDX_W{1'b0}};
          state_s = ST_STOP;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1'b1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_s = {CNT_W{1'b0}};
          if (idx_r == STOP_LAST) begin
            idx_s   = {IDX_W{1'b0}};
            state_s = ST_IDLE;
          end else begin
            idx_s   = idx_r + IDX_W'(1'b1);
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
        idx_s   = {IDX_W{1'b0}};
      end
    endcase

    case (state_s)
      ST_IDLE:   txd_s = 1'b1;
      ST_START:  txd_s = 1'b0;
      ST_DATA:   txd_s = shift_s[0];
      ST_PARITY: txd_s = parity_s;
      ST_STOP:   txd_s = 1'b1;
      default:   txd_s = 1'b1;
    endcase
    done_s = (state_s == ST_STOP) && (cnt_s == CNT_LAST) && (idx_s == STOP_LAST);
  end

  // State, datapath and registered line/handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      shift_r  <= {DATA_W{1'b0}};
      parity_r <= 1'b0;
      TxD      <= 1'b1;
      ready_tx <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      shift_r  <= shift_s;
      parity_r <= parity_s;
      TxD      <= txd_s;
      ready_tx <= (state_s == ST_IDLE);
      busy     <= (state_s != ST_IDLE);
      tx_done  <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus randomized traffic against a frame-level line model.
module tb_uart_tx;

  localparam int OS = 16;
  localparam int DW = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif
  localparam int FRAME = (10 + NSTOP) * OS;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic [7:0] TxData   = 8'h00;
  logic       valid_tx = 1'b0;
  logic       ready_tx, TxD, busy, tx_done;

  int tests   = 0;
  int errors  = 0;
  int cyc     = 0;
  int last_hs = 0;

  uart_tx #(.OVERSAMPLE(OS), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .TxData(TxData), .valid_tx(valid_tx),
    .ready_tx(ready_tx), .TxD(TxD), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected line level at cycle c of a frame carrying d (c = 0 is the first start-bit cycle)
  function automatic logic exp_line(input logic [7:0] d, input int c);
    int b;
    b = c / OS;
    if (b == 0)      return 1'b0;
    else if (b <= 8) return d[b-1];
    else if (b == 9) return ^d;
    else             return 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_txd"}, {31'd0, TxD}, 32'd1);
    check_eq({tag, "_status"}, {29'd0, ready_tx, busy, tx_done}, 32'd4);
  endtask

  // Called at a negedge. Sends d, checks every frame cycle; optionally leaves valid_tx high with nd for the next frame.
  task automatic run_frame(input logic [7:0] d, input bit noise, input bit hold_next,
                           input logic [7:0] nd, input bit chk_pitch, input int abort_at);
    int w;
    w = 0;
    TxData   = d;
    valid_tx = 1'b1;
    while (ready_tx !== 1'b1 && w < 4 * FRAME) begin
      @(negedge clk);
      w++;
    end
    check_eq("hs_ready", {31'd0, ready_tx}, 32'd1);
    if (chk_pitch) check_eq("pitch", cyc - last_hs, FRAME + 1);
    last_hs = cyc;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (c == abort_at) begin
        reset    = 1'b0;
        valid_tx = 1'b0;
        #1;
        check_idle("abort");
        return;
      end
      check_eq("txd", {31'd0, TxD}, {31'd0, exp_line(d, c)});
      check_eq("status", {29'd0, ready_tx, busy, tx_done}, {29'd0, 2'b01, (c == FRAME - 1)});
      if (noise) begin
        valid_tx = 1'($urandom_range(0, 1));
        TxData   = 8'($urandom);
      end else begin
        valid_tx = 1'b0;
      end
    end
    if (hold_next) begin
      TxData   = nd;
      valid_tx = 1'b1;
    end else begin
      valid_tx = 1'b0;
    end
    @(negedge clk);
    check_idle("post");
  endtask

  initial begin
    bit         prev_hold;
    logic [7:0] nd;
    logic [7:0] d;

    repeat (16) @(negedge clk);
    #1;
    check_idle("in_reset");
    reset = 1'b1;
    repeat (32) begin
      @(negedge clk);
      check_idle("idle");
    end

    run_frame(8'h8A, 1'b0, 1'b0, 8'h00, 1'b0, -1);
    repeat (3) @(negedge clk);

    run_frame(8'hAA, 1'b1, 1'b1, 8'h55, 1'b0, -1);
    run_frame(8'h55, 1'b0, 1'b0, 8'h00, 1'b1, -1);

    run_frame(8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, -1);
    run_frame(8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, -1);

    run_frame(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 60);
    repeat (4) begin
      @(negedge clk);
      check_idle("held_reset");
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle("after_abort");
    run_frame(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, -1);

    prev_hold = 1'b0;
    nd        = 8'h00;
    for (int i = 0; i < 16; i++) begin
      bit h;
      d = prev_hold ? nd : 8'($urandom);
      h = 1'($urandom_range(0, 1));
      nd = 8'($urandom);
      run_frame(d, 1'($urandom_range(0, 1)), h, nd, prev_hold, -1);
      if (!h) repeat ($urandom_range(0, 3)) @(negedge clk);
      prev_hold = h;
    end
    if (prev_hold) run_frame(nd, 1'b0, 1'b0, 8'h00, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
